// File: rtl/hello_world_pkg.sv
// Shared types and constants for the hello_world bring-up block.
// State encoding doubles as the LED pattern on z51al/z50al.
package hello_world_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_COUNT = 2'b01,
    ST_HOLD  = 2'b10,
    ST_WRAP  = 2'b11
  } state_t;

  localparam int CNT_W  = 6;
  localparam int LFSR_W = 6;

  // Fibonacci taps for x^6 + x^5 + 1
  localparam int LFSR_TAP_HI = 5;
  localparam int LFSR_TAP_LO = 4;

  localparam logic [CNT_W-1:0]  DEFAULT_MATCH_VALUE = 6'd44;
  localparam logic [LFSR_W-1:0] DEFAULT_LFSR_SEED   = 6'h01;

  function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] v);
    return {v[LFSR_W-2:0], v[LFSR_TAP_HI] ^ v[LFSR_TAP_LO]};
  endfunction

endpackage

// File: rtl/hello_world_sync.sv
// N-stage flop chain bringing an asynchronous pad into the clock domain.
// Clears to 0 on reset so nothing spurious appears during bring-up.
module hello_world_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] ff;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ff <= '0;
    end else begin
      ff <= {ff[STAGES-2:0], d};
    end
  end

  assign q = ff[STAGES-1];

endmodule

// File: rtl/hello_world.sv
// Board bring-up demo: synchronized switches drive a parity flop, an up/down
// counter with match pulse, a 6-bit LFSR and a small FSM, all shown on LEDs.
module hello_world
  import hello_world_pkg::*;
#(
  parameter int                SYNC_STAGES = 2,
  parameter logic [CNT_W-1:0]  MATCH_VALUE = DEFAULT_MATCH_VALUE,
  parameter logic [LFSR_W-1:0] LFSR_SEED   = DEFAULT_LFSR_SEED
) (
  input  logic bertaClock,
  input  logic global_reset,
  input  logic x23,
  input  logic x24,
  input  logic x25,
  output logic xorOutput,
  output logic z0re,
  output logic z1re,
  output logic z2re,
  output logic z3re,
  output logic z4re,
  output logic z5re,
  output logic u34fe,
  output logic u35fe,
  output logic u36fe,
  output logic u37ah,
  output logic u38ah,
  output logic u39ah,
  output logic z50al,
  output logic z51al,
  output logic n44
);

  logic x23s, x24s, x25s;

  hello_world_sync #(.STAGES(SYNC_STAGES)) u_sync_x23 (
    .clk(bertaClock), .rst_n(global_reset), .d(x23), .q(x23s)
  );
  hello_world_sync #(.STAGES(SYNC_STAGES)) u_sync_x24 (
    .clk(bertaClock), .rst_n(global_reset), .d(x24), .q(x24s)
  );
  hello_world_sync #(.STAGES(SYNC_STAGES)) u_sync_x25 (
    .clk(bertaClock), .rst_n(global_reset), .d(x25), .q(x25s)
  );

  logic [CNT_W-1:0]  cnt, cnt_next;
  logic [LFSR_W-1:0] lf, lf_next;
  logic              wrap;
  logic              xor_q, n44_q;
  state_t            state, state_next;

  // Wrap is flagged on the step that crosses 63<->0, so the FSM and the
  // counter register it on the same edge.
  always_comb begin
    cnt_next = cnt;
    wrap     = 1'b0;
    if (x23s) begin
      if (x24s) begin
        cnt_next = cnt - 6'd1;
        wrap     = (cnt == '0);
      end else begin
        cnt_next = cnt + 6'd1;
        wrap     = (cnt == '1);
      end
    end
  end

  always_comb begin
    lf_next = lf;
    if (x25s) begin
      lf_next = lfsr_step(lf);
    end
  end

  always_comb begin
    state_next = state;
    unique case (state)
      ST_IDLE:  if (x23s) state_next = ST_COUNT;
      ST_COUNT: begin
        if (wrap) begin
          state_next = ST_WRAP;
        end else if (!x23s) begin
          state_next = ST_HOLD;
        end
      end
      ST_HOLD:  if (x23s) state_next = ST_COUNT;
      ST_WRAP:  state_next = ST_COUNT;
      default:  state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge bertaClock or negedge global_reset) begin
    if (!global_reset) begin
      cnt   <= '0;
      lf    <= LFSR_SEED;
      state <= ST_IDLE;
      xor_q <= 1'b0;
      n44_q <= 1'b0;
    end else begin
      cnt   <= cnt_next;
      lf    <= lf_next;
      state <= state_next;
      xor_q <= x23s ^ x24s ^ x25s;
      // Qualified by x23s so sitting at the match value does not re-fire.
      n44_q <= (cnt_next == MATCH_VALUE) && x23s;
    end
  end

  assign xorOutput = xor_q;
  assign n44       = n44_q;
  assign {z5re, z4re, z3re, z2re, z1re, z0re}         = cnt;
  assign {u39ah, u38ah, u37ah, u36fe, u35fe, u34fe}   = lf;
  assign {z51al, z50al}                               = state;

endmodule

// File: tb/tb_hello_world.sv
// Directed and random stimulus for hello_world against a cycle-level
// behavioural model of the pad delay line, counter, LFSR and FSM.
module tb_hello_world;

  localparam int SYNC = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic x23 = 1'b0, x24 = 1'b0, x25 = 1'b0;

  logic xorOutput, n44;
  logic z0re, z1re, z2re, z3re, z4re, z5re;
  logic u34fe, u35fe, u36fe, u37ah, u38ah, u39ah;
  logic z50al, z51al;

  hello_world dut (
    .bertaClock(clk), .global_reset(rst_n),
    .x23(x23), .x24(x24), .x25(x25),
    .xorOutput(xorOutput),
    .z0re(z0re), .z1re(z1re), .z2re(z2re), .z3re(z3re), .z4re(z4re), .z5re(z5re),
    .u34fe(u34fe), .u35fe(u35fe), .u36fe(u36fe),
    .u37ah(u37ah), .u38ah(u38ah), .u39ah(u39ah),
    .z50al(z50al), .z51al(z51al),
    .n44(n44)
  );

  // clock / reset
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // model state; pipe[k] holds {x25,x24,x23} as seen k+1 edges ago
  logic [2:0] pipe [SYNC];
  int m_cnt, m_lf, m_st;
  logic m_xor, m_n44;

  function automatic logic [5:0] dut_cnt();
    return {z5re, z4re, z3re, z2re, z1re, z0re};
  endfunction
  function automatic logic [5:0] dut_lf();
    return {u39ah, u38ah, u37ah, u36fe, u35fe, u34fe};
  endfunction
  function automatic logic [1:0] dut_st();
    return {z51al, z50al};
  endfunction
  function automatic logic [15:0] dut_vec();
    return {n44, dut_st(), dut_lf(), dut_cnt(), xorOutput};
  endfunction
  function automatic logic [15:0] exp_vec();
    return {m_n44, 2'(m_st), 6'(m_lf), 6'(m_cnt), m_xor};
  endfunction

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < SYNC; i++) pipe[i] = 3'b000;
    m_cnt = 0; m_lf = 1; m_st = 0; m_xor = 1'b0; m_n44 = 1'b0;
  endtask

  task automatic model_edge();
    logic [2:0] s;
    bit en, down, wrapped;
    s = pipe[SYNC-1];
    en = s[0]; down = s[1];
    wrapped = 0;
    if (en) begin
      wrapped = down ? (m_cnt == 0) : (m_cnt == 63);
      m_cnt = (m_cnt + (down ? 63 : 1)) % 64;
    end
    m_n44 = en && (m_cnt == 44);
    case (m_st)
      0: if (en) m_st = 1;
      1: if (wrapped) m_st = 3; else if (!en) m_st = 2;
      2: if (en) m_st = 1;
      default: m_st = 1;
    endcase
    if (s[2]) m_lf = ((m_lf * 2) % 64) + (((m_lf / 32) + (m_lf / 16)) % 2);
    m_xor = s[0] ^ s[1] ^ s[2];
    for (int i = SYNC - 1; i > 0; i--) pipe[i] = pipe[i-1];
    pipe[0] = {x25, x24, x23};
  endtask

  // driver: one clock, model update, compare whole LED vector
  task automatic step(input string tag);
    @(posedge clk);
    model_edge();
    #1;
    check(tag, dut_vec(), exp_vec());
  endtask

  initial begin
    int n44_seen, wrap_seen, n44_cnt_at, zeros, lat;
    logic [5:0] lf_tab [5];
    lf_tab[0] = 6'h02; lf_tab[1] = 6'h04; lf_tab[2] = 6'h08;
    lf_tab[3] = 6'h10; lf_tab[4] = 6'h21;

    // 1: reset and idle
    model_reset();
    #100;
    check("reset_vec", dut_vec(), 16'h0080);
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step("idle_model");
      check("idle_const", dut_vec(), 16'h0080);
    end

    // 2: count up through the match and the 63->0 wrap
    x23 = 1'b1; x24 = 1'b0;
    n44_seen = 0; wrap_seen = 0; n44_cnt_at = -1;
    for (int i = 0; i < 70; i++) begin
      step("up_model");
      if (n44) begin n44_seen++; n44_cnt_at = int'(dut_cnt()); end
      if (dut_st() == 2'b11) wrap_seen++;
    end
    check("n44_pulses", 16'(n44_seen), 16'd1);
    check("n44_at_cnt", 16'(n44_cnt_at), 16'd44);
    check("wrap_cycles", 16'(wrap_seen), 16'd1);
    check("up_state", 16'(dut_st()), 16'd1);

    // 3: count down through 0->63
    x24 = 1'b1;
    for (int i = 0; i < 100 && dut_cnt() != 6'd0; i++) step("down_model");
    check("down_reach0", 16'(dut_cnt()), 16'd0);
    step("down_wrap_model");
    check("down_wrap_cnt", 16'(dut_cnt()), 16'd63);
    check("down_wrap_st", 16'(dut_st()), 16'd3);
    step("down_after_model");
    check("down_after_st", 16'(dut_st()), 16'd1);
    check("down_after_cnt", 16'(dut_cnt()), 16'd62);

    // 4: full LFSR period with the counter held
    x23 = 1'b0; x25 = 1'b1;
    step("lfsr_sync_model");
    step("lfsr_sync_model");
    check("lfsr_start", 16'(dut_lf()), 16'h01);
    zeros = 0;
    for (int i = 0; i < 63; i++) begin
      step("lfsr_model");
      if (i < 5) check("lfsr_seq", 16'(dut_lf()), 16'(lf_tab[i]));
      if (dut_lf() == 6'd0) zeros++;
    end
    check("lfsr_period", 16'(dut_lf()), 16'h01);
    check("lfsr_no_zero", 16'(zeros), 16'd0);
    check("hold_state", 16'(dut_st()), 16'd2);

    // 5: parity latency per pad
    x25 = 1'b0;
    for (int i = 0; i < 4; i++) step("par_settle");
    for (int p = 0; p < 3; p++) begin
      if (p == 0) x23 = ~x23;
      else if (p == 1) x24 = ~x24;
      else x25 = ~x25;
      lat = -1;
      for (int k = 1; k <= 6 && lat < 0; k++) begin
        step("par_model");
        if (xorOutput == (x23 ^ x24 ^ x25)) lat = k;
      end
      check("par_latency", 16'(lat), 16'd3);
      for (int i = 0; i < 3; i++) step("par_settle");
    end

    // random pads, including simultaneous x23/x25 changes
    for (int i = 0; i < 200; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        x23 = 1'($urandom_range(0, 1));
        x24 = 1'($urandom_range(0, 1));
        x25 = 1'($urandom_range(0, 1));
      end
      step("rand_model");
    end

    // 6: asynchronous reset mid-count at 37
    x23 = 1'b0; x24 = 1'b0; x25 = 1'b0;
    for (int i = 0; i < 4; i++) step("pre_rst_settle");
    x23 = 1'b1;
    for (int i = 0; i < 200 && dut_cnt() != 6'd37; i++) step("pre_rst_model");
    check("pre_rst_cnt", 16'(dut_cnt()), 16'd37);
    #3;
    rst_n = 1'b0;
    #1;
    model_reset();
    check("async_rst_vec", dut_vec(), 16'h0080);
    #2;
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) step("post_rst_model");
    check("post_rst_cnt", 16'(dut_cnt()), 16'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
